// File: rtl/user_id_pkg.sv
// Shared definitions for the user ID readout block: FSM encoding and sizing constants.
package user_id_pkg;

  // Readout controller states; CAP_A/CAP_B form the two-sample capture.
  typedef enum logic [2:0] {
    ST_CAP_A  = 3'd0,
    ST_CAP_B  = 3'd1,
    ST_IDLE   = 3'd2,
    ST_SHIFT  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam int USER_ID_WIDTH_DEFAULT = 32;
  // Serial frame length for the default width: every ID bit plus the parity bit.
  localparam int USER_ID_SER_BITS      = USER_ID_WIDTH_DEFAULT + 1;

  // Counter widths: the divider covers CLKDIV up to 255 and the bit counter covers up to 63.
  localparam int USER_ID_DIV_W = 8;
  localparam int USER_ID_BIT_W = 6;

endpackage

// File: rtl/user_id_readout_if.sv
// Bundles the ID source, capture/dump requests and all readout results.
// The slave side is the readout block; the master side is its user.
interface user_id_readout_if
  import user_id_pkg::*;
#(
  parameter int ID_WIDTH = USER_ID_WIDTH_DEFAULT
);
  logic [ID_WIDTH-1:0] mask_rev;
  logic                rd_req;
  logic                id_valid;
  logic [ID_WIDTH-1:0] id_value;
  logic                id_parity;
  logic                id_mismatch;
  logic                ser_start;
  logic                ser_busy;
  logic                ser_data;
  logic                ser_strobe;
  logic                ser_done;

  modport master (
    output mask_rev, rd_req, ser_start,
    input  id_valid, id_value, id_parity, id_mismatch,
    input  ser_busy, ser_data, ser_strobe, ser_done
  );

  modport slave (
    input  mask_rev, rd_req, ser_start,
    output id_valid, id_value, id_parity, id_mismatch,
    output ser_busy, ser_data, ser_strobe, ser_done
  );
endinterface

// File: rtl/user_id_bit_timer.sv
// Serial bit timer: divides clk by CLKDIV while running, flagging the first and
// last cycle of each serial bit. The divider parks at its reload value when idle,
// so the first running cycle is always the start of a bit.
module user_id_bit_timer
  import user_id_pkg::*;
#(
  parameter int CLKDIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic run_i,
  output logic bit_tick_o,
  output logic first_cycle_o
);

  localparam logic [USER_ID_DIV_W-1:0] DIV_RELOAD = USER_ID_DIV_W'(CLKDIV - 1);

  logic [USER_ID_DIV_W-1:0] div_q;
  logic [USER_ID_DIV_W-1:0] div_d;

  // Count down while running; reload at the end of each bit or when stopped.
  always_comb begin
    div_d = DIV_RELOAD;
    if (run_i && (div_q != '0)) begin
      div_d = div_q - 1'b1;
    end
  end

  // Divider register.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= DIV_RELOAD;
    end else begin
      div_q <= div_d;
    end
  end

  assign first_cycle_o = run_i && (div_q == DIV_RELOAD);
  assign bit_tick_o    = run_i && (div_q == '0);

endmodule

// File: rtl/user_id_readout.sv
// User ID readout: snapshots the tie-cell ID after reset or on request, confirms it
// over two samples, publishes it with even parity, and can dump it serially
// (ID bits then parity) at CLKDIV clocks per bit.
module user_id_readout
  import user_id_pkg::*;
#(
  parameter int ID_WIDTH  = USER_ID_WIDTH_DEFAULT,
  parameter int CLKDIV    = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              reset,
  user_id_readout_if.slave  bus
);

  localparam int                       IDX_W     = $clog2(ID_WIDTH);
  localparam logic [USER_ID_BIT_W-1:0] BIT_FIRST = USER_ID_BIT_W'(ID_WIDTH);

  state_e                   state_q;
  state_e                   state_d;
  logic [ID_WIDTH-1:0]      snap_q;
  logic [ID_WIDTH-1:0]      snap_d;
  logic                     parity_q;
  logic                     parity_d;
  logic                     mismatch_q;
  logic                     mismatch_d;
  logic [USER_ID_BIT_W-1:0] bitcnt_q;
  logic [USER_ID_BIT_W-1:0] bitcnt_d;
  logic [IDX_W-1:0]         ser_idx;
  logic                     ser_bit;
  logic                     in_shift;
  logic                     bit_tick;
  logic                     first_cycle;

  assign in_shift = (state_q == ST_SHIFT);

  user_id_bit_timer #(
    .CLKDIV (CLKDIV)
  ) u_timer (
    .clk           (clk),
    .reset         (reset),
    .run_i         (in_shift),
    .bit_tick_o    (bit_tick),
    .first_cycle_o (first_cycle)
  );

  // Next-state logic; requests are honoured only in IDLE, with re-capture winning.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CAP_A: state_d = ST_CAP_B;
      ST_CAP_B: state_d = ST_IDLE;
      ST_IDLE: begin
        if (bus.rd_req) begin
          state_d = ST_CAP_A;
        end else if (bus.ser_start) begin
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bit_tick && (bitcnt_q == '0)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_CAP_A;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_CAP_A;
    end else begin
      state_q <= state_d;
    end
  end

  // Snapshot, parity, sticky mismatch and bit counter updates.
  // A differing second sample is taken as the newer value and flagged.
  always_comb begin
    snap_d     = snap_q;
    parity_d   = parity_q;
    mismatch_d = mismatch_q;
    bitcnt_d   = bitcnt_q;
    case (state_q)
      ST_CAP_A: begin
        snap_d   = bus.mask_rev;
        parity_d = ^bus.mask_rev;
      end
      ST_CAP_B: begin
        if (bus.mask_rev != snap_q) begin
          mismatch_d = 1'b1;
          snap_d     = bus.mask_rev;
          parity_d   = ^bus.mask_rev;
        end
      end
      ST_IDLE: bitcnt_d = BIT_FIRST;
      ST_SHIFT: begin
        if (bit_tick && (bitcnt_q != '0)) begin
          bitcnt_d = bitcnt_q - 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Snapshot registers; reset clears them so every output starts at 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      snap_q     <= '0;
      parity_q   <= 1'b0;
      mismatch_q <= 1'b0;
      bitcnt_q   <= '0;
    end else begin
      snap_q     <= snap_d;
      parity_q   <= parity_d;
      mismatch_q <= mismatch_d;
      bitcnt_q   <= bitcnt_d;
    end
  end

  // Serial bit select: bitcnt counts ID_WIDTH..1 over the ID bits, 0 is the parity slot.
  always_comb begin
    if (MSB_FIRST != 0) begin
      ser_idx = IDX_W'(bitcnt_q - 1'b1);
    end else begin
      ser_idx = IDX_W'(BIT_FIRST - bitcnt_q);
    end
    ser_bit = (bitcnt_q == '0) ? parity_q : snap_q[ser_idx];
  end

  assign bus.id_valid    = (state_q == ST_IDLE) || (state_q == ST_SHIFT) || (state_q == ST_DONE);
  assign bus.id_value    = snap_q;
  assign bus.id_parity   = parity_q;
  assign bus.id_mismatch = mismatch_q;
  assign bus.ser_busy    = in_shift;
  assign bus.ser_data    = in_shift && ser_bit;
  assign bus.ser_strobe  = first_cycle;
  assign bus.ser_done    = (state_q == ST_DONE);

endmodule

// File: tb/tb_user_id_readout.sv
// Bench for user_id_readout: two instances (CLKDIV=4 MSB-first, CLKDIV=1 LSB-first),
// directed and random IDs checked against a serial-frame model built from the ID.
module tb_user_id_readout;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int   total = 0;
  int   bad   = 0;

  user_id_readout_if #(.ID_WIDTH(32)) ifa ();
  user_id_readout_if #(.ID_WIDTH(32)) ifb ();

  user_id_readout #(.ID_WIDTH(32), .CLKDIV(4), .MSB_FIRST(1)) dut_a (
    .clk   (clk),
    .reset (rst_a),
    .bus   (ifa.slave)
  );

  user_id_readout #(.ID_WIDTH(32), .CLKDIV(1), .MSB_FIRST(0)) dut_b (
    .clk   (clk),
    .reset (rst_b),
    .bus   (ifb.slave)
  );

  always #5 clk = ~clk;

  wire [3:0] obs_a = {ifa.ser_busy, ifa.ser_data, ifa.ser_strobe, ifa.ser_done};
  wire [3:0] obs_b = {ifb.ser_busy, ifb.ser_data, ifb.ser_strobe, ifb.ser_done};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] o, input logic [63:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // Bit k of the serial frame: ID bits in the chosen order, then even parity.
  function automatic logic frame_bit(input logic [31:0] m, input int k, input bit msb);
    if (k == 32) return logic'($countones(m) % 2);
    return msb ? m[31 - k] : m[k];
  endfunction

  function automatic logic [3:0] obs(input bit sel);
    return sel ? obs_b : obs_a;
  endfunction

  task automatic set_start(input bit sel, input logic v);
    if (sel) ifb.ser_start = v;
    else     ifa.ser_start = v;
  endtask

  // Runs one dump, checking every cycle. pulse_bit >= 0 fires a stray ser_start at
  // the start of that bit; rst_bit >= 0 resets instance A at the start of that bit.
  task automatic dump(input bit sel, input int div, input bit msb, input logic [31:0] m,
                      input int pulse_bit, input int rst_bit);
    logic [3:0] e;
    check("idle_ser", 64'(obs(sel)), 64'h0);
    set_start(sel, 1'b1);
    tick();
    set_start(sel, 1'b0);
    for (int c = 0; c < 33 * div; c++) begin
      e = {1'b1, frame_bit(m, c / div, msb), (c % div) == 0, 1'b0};
      check("dump_cycle", 64'(obs(sel)), 64'(e));
      if (rst_bit >= 0 && c == rst_bit * div) begin
        rst_a = 1'b1;
        tick();
        check("mid_dump_reset", 64'({obs_a, ifa.id_valid, ifa.id_mismatch}), 64'h0);
        return;
      end
      set_start(sel, (pulse_bit >= 0 && c == pulse_bit * div));
      tick();
    end
    set_start(sel, 1'b0);
    check("ser_done", 64'(obs(sel)), 64'h1);
    tick();
    check("after_done", 64'(obs(sel)), 64'h0);
  endtask

  // Re-capture on instance A with a stable ID, checking the old value is held meanwhile.
  task automatic recapture_a(input logic [31:0] m, input logic [31:0] prev);
    ifa.mask_rev = m;
    ifa.rd_req   = 1'b1;
    tick();
    ifa.rd_req   = 1'b0;
    check("recap_hold", 64'({ifa.id_valid, ifa.id_value}), 64'({1'b0, prev}));
    tick();
    tick();
    check("recap_value", 64'({ifa.id_valid, ifa.id_parity, ifa.id_value}),
          64'({1'b1, logic'($countones(m) % 2), m}));
  endtask

  initial begin
    logic [31:0] prev;
    logic [31:0] m;
    ifa.mask_rev = 32'h0; ifa.rd_req = 1'b0; ifa.ser_start = 1'b0;
    ifb.mask_rev = 32'h8000_0001; ifb.rd_req = 1'b0; ifb.ser_start = 1'b0;

    // Reset state and capture latency.
    tick();
    tick();
    check("reset_state", 64'({ifa.id_valid, ifa.id_value, ifa.id_parity, ifa.id_mismatch, obs_a}), 64'h0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    tick();
    check("valid_edge1", 64'(ifa.id_valid), 64'h0);
    tick();
    check("valid_edge2", 64'({ifa.id_valid, ifa.id_value, ifa.id_parity, ifa.id_mismatch}),
          64'({1'b1, 32'h0, 1'b0, 1'b0}));
    check("b_capture", 64'({ifb.id_valid, ifb.id_parity, ifb.id_value}),
          64'({1'b1, 1'b0, 32'h8000_0001}));

    // Directed frame, then random IDs.
    recapture_a(32'hA5A5_0001, 32'h0);
    dump(1'b0, 4, 1'b1, 32'hA5A5_0001, -1, -1);
    prev = 32'hA5A5_0001;
    for (int r = 0; r < 3; r++) begin
      m = $urandom;
      recapture_a(m, prev);
      dump(1'b0, 4, 1'b1, m, -1, -1);
      prev = m;
    end
    check("no_mismatch", 64'(ifa.id_mismatch), 64'h0);

    // ID changes between the two capture samples.
    rst_a = 1'b1;
    ifa.mask_rev = 32'h1;
    tick();
    rst_a = 1'b0;
    tick();
    ifa.mask_rev = 32'h3;
    tick();
    check("mismatch_set", 64'({ifa.id_valid, ifa.id_mismatch, ifa.id_value}), 64'({1'b1, 1'b1, 32'h3}));
    recapture_a(32'h3, 32'h3);
    check("mismatch_sticky", 64'(ifa.id_mismatch), 64'h1);

    // Simultaneous requests: re-capture wins.
    ifa.rd_req = 1'b1;
    ifa.ser_start = 1'b1;
    tick();
    ifa.rd_req = 1'b0;
    ifa.ser_start = 1'b0;
    check("both_req", 64'({ifa.ser_busy, ifa.id_valid}), 64'h0);
    tick();
    tick();
    check("both_req_done", 64'({ifa.ser_busy, ifa.id_valid}), 64'h1);

    // Stray start mid-dump is ignored, then reset at bit 17 aborts a dump.
    dump(1'b0, 4, 1'b1, 32'h3, 10, -1);
    dump(1'b0, 4, 1'b1, 32'h3, -1, 17);
    rst_a = 1'b0;
    tick();
    check("post_reset_edge1", 64'(ifa.id_valid), 64'h0);
    tick();
    check("post_reset_edge2", 64'({ifa.id_valid, ifa.id_mismatch, ifa.id_value}), 64'({1'b1, 1'b0, 32'h3}));

    // CLKDIV=1, LSB-first instance.
    dump(1'b1, 1, 1'b0, 32'h8000_0001, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
